// File: rtl/uart_tx_fifo_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : uart_tx_fifo_if                                                  |
// | Brief    : Core-side write port and status bundle of the UART transmitter.  |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
interface uart_tx_fifo_if #(
  parameter int FIFO_DEPTH = 16
);
  localparam int c_lvl_w = $clog2(FIFO_DEPTH) + 1;

  logic               uart_wr_i;
  logic [7:0]         uart_dat_i;
  logic               uart_full_o;
  logic               uart_empty_o;
  logic               uart_busy_o;
  logic [c_lvl_w-1:0] uart_level_o;

  modport master (
    output uart_wr_i, uart_dat_i,
    input  uart_full_o, uart_empty_o, uart_busy_o, uart_level_o
  );

  modport slave (
    input  uart_wr_i, uart_dat_i,
    output uart_full_o, uart_empty_o, uart_busy_o, uart_level_o
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : uart_tx_fifo                                                     |
// | Brief    : Buffered UART transmitter, 5..8 data bits, parity, 1/2 stops.    |
// |            UART_TX_FIFO_EN selects the FIFO; otherwise one holding register.|
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
module uart_tx_fifo #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  wire            sys_clk_i,
  input  wire            sys_rst_n_i,
  uart_tx_fifo_if.slave  bus,
  output logic           uart_tx_o
);

  localparam int c_div   = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int c_cnt_w = (c_div > 1) ? $clog2(c_div) : 1;
  localparam int c_lvl_w = $clog2(FIFO_DEPTH) + 1;

  localparam logic [c_cnt_w-1:0] c_div_last  = c_cnt_w'(c_div - 1);
  localparam logic [2:0]         c_last_bit  = 3'(DATA_BITS - 1);
  localparam logic               c_last_stop = 1'(STOP_BITS - 1);
  localparam logic               c_par_odd   = (PARITY == 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  state_t                 r_state, w_state_n;
  logic                   r_tx, w_tx_n;
  logic [DATA_BITS-1:0]   r_shift, w_shift_n;
  logic [2:0]             r_bit_idx, w_bit_idx_n;
  logic                   r_stop_idx, w_stop_idx_n;
  logic                   r_par, w_par_n;
  logic [c_cnt_w-1:0]     r_cnt, w_cnt_n;

  logic                   w_tick;
  logic                   w_start;
  logic                   w_pop;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_wr_acc;
  logic [DATA_BITS-1:0]   w_head;
  logic                   w_unused_dat;

  // Data bits above DATA_BITS-1 are deliberately dropped.
  assign w_unused_dat = ^bus.uart_dat_i;

  assign w_wr_acc = bus.uart_wr_i && !w_full;

`ifdef UART_TX_FIFO_EN
  localparam int                 c_ptr_w    = $clog2(FIFO_DEPTH);
  localparam logic [c_lvl_w-1:0] c_full_lvl = c_lvl_w'(FIFO_DEPTH);

  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0]   r_wr_ptr;
  logic [c_ptr_w-1:0]   r_rd_ptr;
  logic [c_lvl_w-1:0]   r_level;

  assign w_full  = (r_level == c_full_lvl);
  assign w_empty = (r_level == '0);
  assign w_head  = r_mem[r_rd_ptr];
  assign bus.uart_level_o = r_level;

  always_ff @(negedge sys_clk_i) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= bus.uart_dat_i[DATA_BITS-1:0];
    end
  end

  // Pointers wrap naturally; the level alone tells full from empty.
  always_ff @(negedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_wr_acc, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end
`else
  logic                 r_hold_vld;
  logic [DATA_BITS-1:0] r_hold;

  assign w_full  = r_hold_vld;
  assign w_empty = !r_hold_vld;
  assign w_head  = r_hold;
  assign bus.uart_level_o = {{(c_lvl_w-1){1'b0}}, r_hold_vld};

  // A write is only accepted while empty, so it can never coincide with a pop.
  always_ff @(negedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      r_hold_vld <= 1'b0;
      r_hold     <= '0;
    end else if (w_wr_acc) begin
      r_hold_vld <= 1'b1;
      r_hold     <= bus.uart_dat_i[DATA_BITS-1:0];
    end else if (w_pop) begin
      r_hold_vld <= 1'b0;
    end
  end
`endif

  assign bus.uart_full_o  = w_full;
  assign bus.uart_empty_o = w_empty;
  assign bus.uart_busy_o  = (r_state != ST_IDLE) || !w_empty;
  assign uart_tx_o        = r_tx;

  assign w_tick = (r_cnt == c_div_last);

  always_ff @(negedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      r_state    <= ST_IDLE;
      r_tx       <= 1'b1;
      r_shift    <= '0;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
      r_par      <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_n;
      r_tx       <= w_tx_n;
      r_shift    <= w_shift_n;
      r_bit_idx  <= w_bit_idx_n;
      r_stop_idx <= w_stop_idx_n;
      r_par      <= w_par_n;
      r_cnt      <= w_cnt_n;
    end
  end

  always_comb begin
    w_state_n    = r_state;
    w_tx_n       = r_tx;
    w_shift_n    = r_shift;
    w_bit_idx_n  = r_bit_idx;
    w_stop_idx_n = r_stop_idx;
    w_par_n      = r_par;
    w_cnt_n      = (r_state == ST_IDLE || w_tick) ? '0 : r_cnt + 1'b1;
    w_start      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_start = !w_empty;
      end
      ST_START: begin
        if (w_tick) begin
          w_tx_n      = r_shift[0];
          w_shift_n   = r_shift >> 1;
          w_bit_idx_n = '0;
          w_state_n   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          if (r_bit_idx == c_last_bit) begin
            if (PARITY != 0) begin
              w_tx_n    = r_par;
              w_state_n = ST_PARITY;
            end else begin
              w_tx_n       = 1'b1;
              w_stop_idx_n = 1'b0;
              w_state_n    = ST_STOP;
            end
          end else begin
            w_tx_n      = r_shift[0];
            w_shift_n   = r_shift >> 1;
            w_bit_idx_n = r_bit_idx + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (w_tick) begin
          w_tx_n       = 1'b1;
          w_stop_idx_n = 1'b0;
          w_state_n    = ST_STOP;
        end
      end
      ST_STOP: begin
        if (w_tick) begin
          if (r_stop_idx == c_last_stop) begin
            w_start   = !w_empty;
            w_state_n = ST_IDLE;
          end else begin
            w_stop_idx_n = r_stop_idx + 1'b1;
          end
        end
      end
      default: begin
        w_state_n = ST_IDLE;
        w_tx_n    = 1'b1;
      end
    endcase

    // Loading the next byte straight out of STOP leaves no idle gap on the line.
    if (w_start) begin
      w_shift_n = w_head;
      w_par_n   = (^w_head) ^ c_par_odd;
      w_tx_n    = 1'b0;
      w_cnt_n   = '0;
      w_state_n = ST_START;
    end
  end

  assign w_pop = w_start;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : tb_uart_tx_fifo                                                  |
// | Brief    : Directed bench for uart_tx_fifo: 8N1, 8E1, 8O1, 7N2 instances.   |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
module tb_uart_tx_fifo;

  localparam int DIV   = 10;
  localparam int NDUT  = 4;
  localparam int LVL_W = 5;
  localparam int LOG_N = 4096;

  typedef struct {
    int          dut;
    logic [7:0]  data;
    logic [11:0] bits;   // line value per bit slot, slot 0 = start bit
    int          nbits;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             wr    [NDUT];
  logic [7:0]       dat   [NDUT];
  logic             tx    [NDUT];
  logic             full  [NDUT];
  logic             empty [NDUT];
  logic             busy  [NDUT];
  logic [LVL_W-1:0] level [NDUT];

  int n_cmp = 0;
  int n_err = 0;

  logic       tx_log [LOG_N];
  int         sidx;
  int         busy_cyc;
  int         rx_n;
  logic [7:0] rx_byte  [32];
  int         rx_start [32];
  logic       rx_stop  [32];

  vec_t vecs [8];

  always #5 clk = ~clk;

  // dut0 = 8N1, dut1 = 8E1, dut2 = 8O1, dut3 = 7N2; all at DIV = 10
  for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
    localparam int PAR = (gi == 1) ? 2 : (gi == 2) ? 1 : 0;
    localparam int DB  = (gi == 3) ? 7 : 8;
    localparam int SB  = (gi == 3) ? 2 : 1;

    uart_tx_fifo_if #(.FIFO_DEPTH(16)) u_if ();

    assign u_if.uart_wr_i  = wr[gi];
    assign u_if.uart_dat_i = dat[gi];
    assign full[gi]        = u_if.uart_full_o;
    assign empty[gi]       = u_if.uart_empty_o;
    assign busy[gi]        = u_if.uart_busy_o;
    assign level[gi]       = u_if.uart_level_o;

    uart_tx_fifo #(
      .CLK_HZ     (1_000_000),
      .BAUD       (100_000),
      .DATA_BITS  (DB),
      .PARITY     (PAR),
      .STOP_BITS  (SB),
      .FIFO_DEPTH (16)
    ) u_dut (
      .sys_clk_i   (clk),
      .sys_rst_n_i (rst_n),
      .bus         (u_if.slave),
      .uart_tx_o   (tx[gi])
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic write_byte(input int d, input logic [7:0] b);
    @(posedge clk);
    wr[d]  = 1'b1;
    dat[d] = b;
    @(posedge clk);
    wr[d]  = 1'b0;
  endtask

  task automatic run_vector(input int vi, input vec_t v);
    int d;
    int bad;
    d = v.dut;
    write_byte(d, v.data);
    check($sformatf("v%0d_empty_after_wr", vi), 32'(empty[d]), 32'd0);
    check($sformatf("v%0d_level_after_wr", vi), 32'(level[d]), 32'd1);
    @(posedge clk);
    check($sformatf("v%0d_level_after_pop", vi), 32'(level[d]), 32'd0);
    for (int s = 0; s < v.nbits; s++) begin
      bad = 0;
      for (int c = 0; c < DIV; c++) begin
        if (tx[d] !== v.bits[s]) bad++;
        if (s == v.nbits - 1 && c == DIV - 1)
          check($sformatf("v%0d_busy_last_cycle", vi), 32'(busy[d]), 32'd1);
        @(posedge clk);
      end
      check($sformatf("v%0d_slot%0d_bad_cycles(want_tx=%0b)", vi, s, v.bits[s]), 32'(bad), 32'd0);
    end
    check($sformatf("v%0d_busy_after_frame", vi), 32'(busy[d]), 32'd0);
    check($sformatf("v%0d_tx_idle", vi), 32'(tx[d]), 32'd1);
  endtask

  task automatic mon_reset();
    sidx     = 0;
    busy_cyc = 0;
  endtask

  task automatic step();
    @(posedge clk);
    tx_log[sidx] = tx[0];
    if (busy[0]) busy_cyc++;
    if (sidx < LOG_N - 1) sidx++;
  endtask

  task automatic wait_idle();
    while (busy[0] && sidx < LOG_N - 100) step();
  endtask

  // Independent 8N1 receiver over the logged dut0 line, sampling mid-bit.
  task automatic decode_log();
    int         j;
    logic [7:0] b;
    rx_n = 0;
    j    = 1;
    while (j < sidx) begin
      if (tx_log[j-1] && !tx_log[j] && (j + 95 < sidx) && rx_n < 32) begin
        for (int k = 0; k < 8; k++) b[k] = tx_log[j + 10 * (k + 1) + 5];
        rx_byte[rx_n]  = b;
        rx_start[rx_n] = j;
        rx_stop[rx_n]  = tx_log[j + 95];
        rx_n++;
        j += 96;
      end else begin
        j++;
      end
    end
  endtask

  initial begin
    int bad;

    vecs[0] = '{dut: 0, data: 8'h55, bits: 12'h2AA, nbits: 10};
    vecs[1] = '{dut: 0, data: 8'hA3, bits: 12'h346, nbits: 10};
    vecs[2] = '{dut: 1, data: 8'h07, bits: 12'h60E, nbits: 11};
    vecs[3] = '{dut: 1, data: 8'h03, bits: 12'h406, nbits: 11};
    vecs[4] = '{dut: 2, data: 8'h07, bits: 12'h40E, nbits: 11};
    vecs[5] = '{dut: 2, data: 8'h00, bits: 12'h600, nbits: 11};
    vecs[6] = '{dut: 3, data: 8'hFF, bits: 12'h3FE, nbits: 10};
    vecs[7] = '{dut: 3, data: 8'hAA, bits: 12'h354, nbits: 10};

    for (int d = 0; d < NDUT; d++) begin
      wr[d]  = 1'b0;
      dat[d] = 8'h00;
    end
    mon_reset();

    repeat (3) @(posedge clk);
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("rst_tx%0d", d),    32'(tx[d]),    32'd1);
      check($sformatf("rst_full%0d", d),  32'(full[d]),  32'd0);
      check($sformatf("rst_empty%0d", d), 32'(empty[d]), 32'd1);
      check($sformatf("rst_busy%0d", d),  32'(busy[d]),  32'd0);
      check($sformatf("rst_level%0d", d), 32'(level[d]), 32'd0);
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Reset in the middle of a zero-data frame with one byte still queued
    write_byte(0, 8'h00);
    @(posedge clk);
    write_byte(0, 8'h00);
    repeat (30) @(posedge clk);
    check("mid_frame_tx_low", 32'(tx[0]), 32'd0);
    check("mid_frame_level",  32'(level[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_tx",    32'(tx[0]),    32'd1);
    check("async_rst_empty", 32'(empty[0]), 32'd1);
    check("async_rst_level", 32'(level[0]), 32'd0);
    check("async_rst_busy",  32'(busy[0]),  32'd0);
    repeat (2) @(posedge clk);
    rst_n = 1'b1;
    @(posedge clk);

    for (int i = 0; i < 8; i++) run_vector(i, vecs[i]);

`ifdef UART_TX_FIFO_EN
    // 1 + 17 writes of 0xFF: the 17th queued write hits a full FIFO and is dropped
    mon_reset();
    @(posedge clk);
    wr[0]  = 1'b1;
    dat[0] = 8'hFF;
    step();
    wr[0] = 1'b0;
    step();
    check("fifo_level_after_pop", 32'(level[0]), 32'd0);
    for (int k = 0; k < 17; k++) begin
      wr[0] = 1'b1;
      step();
    end
    wr[0] = 1'b0;
    check("fifo_level_full", 32'(level[0]), 32'd16);
    check("fifo_full_flag",  32'(full[0]),  32'd1);
    wait_idle();
    check("fifo_drained_busy", 32'(busy[0]), 32'd0);
    // busy from the write edge through 17 frames of 100 cycles each
    check("fifo_busy_cycles", 32'(busy_cyc), 32'(1 + 17 * 100));
    decode_log();
    check("fifo_frames", 32'(rx_n), 32'd17);
    bad = 0;
    for (int k = 0; k < rx_n; k++) begin
      if (rx_byte[k] !== 8'hFF || rx_stop[k] !== 1'b1) bad++;
      if (k > 0 && rx_start[k] - rx_start[k-1] != 100) bad++;
    end
    check("fifo_frame_content_and_gap", 32'(bad), 32'd0);
`else
    // Holding register: second write right behind the first is dropped
    mon_reset();
    @(posedge clk);
    wr[0]  = 1'b1;
    dat[0] = 8'h11;
    step();
    check("hold_level_1", 32'(level[0]), 32'd1);
    check("hold_full_1",  32'(full[0]),  32'd1);
    dat[0] = 8'h22;
    step();
    check("hold_level_popped", 32'(level[0]), 32'd0);
    check("hold_full_popped",  32'(full[0]),  32'd0);
    dat[0] = 8'h33;
    step();
    check("hold_level_2", 32'(level[0]), 32'd1);
    check("hold_full_2",  32'(full[0]),  32'd1);
    dat[0] = 8'h44;
    step();
    wr[0] = 1'b0;
    check("hold_level_drop", 32'(level[0]), 32'd1);
    wait_idle();
    check("hold_busy_cycles", 32'(busy_cyc), 32'd201);
    decode_log();
    check("hold_frames", 32'(rx_n), 32'd2);
    check("hold_byte0", 32'(rx_byte[0]), 32'h11);
    check("hold_byte1", 32'(rx_byte[1]), 32'h33);
    check("hold_gap", 32'(rx_start[1] - rx_start[0]), 32'd100);
    check("hold_stops", 32'({rx_stop[0], rx_stop[1]}), 32'd3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
